digit_scan: RTL and testbench
=============================

// Module: digit_scan
// PURPOSE
//  Time-multiplexed hex driver for an N-digit common-anode/cathode 7-segment bank.
//  Captures a packed nibble word and scans digits one slot at a time.
//  Adds tear-free frame-synchronous update, per-digit blanking, leading-zero
//  suppression and blink. Sits between the CPU debug/IO bus and the board display pins.
// PARAMETERS
//  NUM_DIGITS     4      digits driven; >=2
//  SCAN_DIV       50000  clk cycles per digit slot; >=2
//  BLANK_CYC      16     cycles at slot start with all selects off (anti-ghost); 1..SCAN_DIV-1
//  BLINK_FRAMES   64     full scan frames per blink half-period; >=1
//  SEG_ACT_LOW    0      1 = segment outputs active-low
//  SEL_ACT_LOW    0      1 = digit selects active-low
// PORTS
//  clk            in   1             system clock
//  rst            in   1             async reset, active-low
//  digiti_data    in   4*NUM_DIGITS  nibble k = digit k (digit 0 = rightmost, LS)
//  digiti_load    in   1             1-cycle strobe: capture digiti_data
//  digiti_blank   in   NUM_DIGITS    per-digit force-off mask (sampled live)
//  digiti_lzs     in   1             leading-zero suppression enable (live)
//  digiti_blink   in   1             blink enable (live)
//  digito_seg     out  7             segments {g,f,e,d,c,b,a}, bit0 = a
//  digito_sel     out  NUM_DIGITS    one-hot digit select
//  digito_ack     out  1             1-cycle pulse: loaded value now displayed
// BEHAVIOUR
//  Reset (rst=0, async): seg = OFF, sel = none active, ack = 0, slot idx = 0,
//   div cnt = 0, shadow = display = 0, pending = 0, blink phase = 0, frame cnt = 0.
//   OFF = 7'h00 (SEG_ACT_LOW=0) / 7'h7F; sel none = all 0 / all 1 likewise.
//  Encoding (active-high): 0 3F,1 06,2 5B,3 4F,4 66,5 6D,6 7D,7 07,8 7F,9 6F,
//   A 77,b 7C,C 39,d 5E,E 79,F 71.
//  Divider: cnt 0..SCAN_DIV-1; at cnt==SCAN_DIV-1 wraps to 0, idx <= (idx+1) mod NUM_DIGITS.
//  Frame boundary = divider wrap with idx==NUM_DIGITS-1.
//  Slot FSM per slot: BLANK (cnt < BLANK_CYC): sel none, seg OFF;
//   DRIVE (cnt >= BLANK_CYC): sel bit idx active, seg = decoded digit idx.
//   seg/sel are registered: new slot value appears on the clk edge cnt becomes BLANK_CYC.
//  Load/update: digiti_load writes shadow, sets pending. At frame boundary with
//   pending: display <= shadow, pending <= 0, ack = 1 on next cycle.
//   Repeated loads before boundary: last wins, single ack.
//   Load coinciding with boundary: display <= digiti_data directly (bypass), pending
//   stays 0, ack next cycle. Display never changes mid-frame.
//  Digit k shows OFF if: digiti_blank[k]; or lzs and k>0 and display nibbles
//   k..NUM_DIGITS-1 all zero; or blink and blink phase==1. Digit 0 never LZ-suppressed.
//  Blink: frame cnt counts boundaries 0..BLINK_FRAMES-1; at wrap blink phase toggles.
//   Counter runs regardless of digiti_blink; deasserting blink restores digits next DRIVE.
//  Polarity: SEG_ACT_LOW / SEL_ACT_LOW invert at output registers only.
//  Mid-operation reset: all state to reset values immediately; pending load lost, no ack.
// STRUCTURE
//  Package digit_pkg: 16-entry hex->seg constant table, SEG_OFF, segment bit-order
//   localparams, $clog2-based width helpers.
//  Sub-module hex7_dec: combinational 4b -> 7b decoder (active-high), one instance
//   on the muxed current-slot nibble.
//  Top: divider, slot idx, slot FSM, shadow/display/pending regs, LZS mask,
//   blink counter, output regs.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2, active-high)
//  Reset then idle -> seg 00, sel 0000 until first DRIVE; then sel 0001, seg 3F;
//   scan order 0001,0010,0100,1000 each 3 cycles after 1 blank cycle.
//  Load 16'h1A2F mid-frame -> old value until boundary; ack 1 cycle after;
//   digits seg 71,5B,77,06 for idx 0..3.
//  Two loads 16'h1111 then 16'h2222 in one frame -> single ack, shows 2222 (5B x4).
//  Load 16'h00C0 at boundary cycle, lzs=1 -> ack next cycle; idx3,idx2 OFF, idx1 39, idx0 3F.
//  blink=1 -> digits OFF for 2 frames, on for 2, repeating; blank=4'b0100 -> idx2 always OFF.
//  rst low mid-DRIVE with pending load -> outputs OFF/none same cycle, no ack after release.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table,
// segment bit order and counter width helper.
package digit_pkg;

  // Segment bit order within a glyph: {g,f,e,d,c,b,a}, a in bit 0
  localparam int unsigned SEG_A_BIT = 0;
  localparam int unsigned SEG_G_BIT = 6;
  localparam int unsigned SEG_W     = SEG_G_BIT - SEG_A_BIT + 1;

  // Active-high "all segments dark"
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Active-high glyphs for 0..9, A, b, C, d, E, F
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bits needed to count 0..n-1, never less than one
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_scan_if.sv
// Bus-side bundle of the scan driver: capture/control inputs and display pins.
interface digit_scan_if
  import digit_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] digiti_data;
  logic                    digiti_load;
  logic [NUM_DIGITS-1:0]   digiti_blank;
  logic                    digiti_lzs;
  logic                    digiti_blink;
  logic [SEG_W-1:0]        digito_seg;
  logic [NUM_DIGITS-1:0]   digito_sel;
  logic                    digito_ack;

  modport master (
    output digiti_data, digiti_load, digiti_blank, digiti_lzs, digiti_blink,
    input  digito_seg, digito_sel, digito_ack
  );

  modport slave (
    input  digiti_data, digiti_load, digiti_blank, digiti_lzs, digiti_blink,
    output digito_seg, digito_sel, digito_ack
  );

endinterface

// File: rtl/digit_scan_hex7_dec.sv
// Combinational nibble to active-high 7-segment glyph decoder.
module hex7_dec
  import digit_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);

  // Table lookup of the glyph for the nibble
  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/digit_scan.sv
// Time-multiplexed hex display driver with frame-synchronous update,
// per-digit blanking, leading-zero suppression and blink.
module digit_scan
  import digit_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 16,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          SEG_ACT_LOW  = 1'b0,
  parameter bit          SEL_ACT_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  digit_scan_if.slave bus
);

  localparam int unsigned CNT_W = cnt_w(SCAN_DIV);
  localparam int unsigned IDX_W = cnt_w(NUM_DIGITS);
  localparam int unsigned FRM_W = cnt_w(BLINK_FRAMES);
  localparam int unsigned DAT_W = 4 * NUM_DIGITS;

  localparam logic [0:0] SLOT_BLANK = 1'b0;
  localparam logic [0:0] SLOT_DRIVE = 1'b1;

  localparam logic [SEG_W-1:0]      SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACT_LOW ? '1 : '0;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DAT_W-1:0]      shadow_q, shadow_d;
  logic [DAT_W-1:0]      display_q, display_d;
  logic                  pending_q, pending_d;
  logic                  ack_q, ack_d;
  logic [FRM_W-1:0]      frame_q, frame_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic                  wrap;
  logic                  boundary;
  logic [0:0]            slot_phase;
  logic                  all_zero;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  digit_off;
  logic [3:0]            cur_nib;
  logic [SEG_W-1:0]      cur_seg;
  logic [SEG_W-1:0]      seg_raw;
  logic [NUM_DIGITS-1:0] sel_raw;

  // Slot divider, slot index and the blank/drive phase of the upcoming cycle
  always_comb begin
    wrap     = (cnt_q == CNT_W'(SCAN_DIV - 1));
    boundary = wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    slot_phase = (cnt_d < CNT_W'(BLANK_CYC)) ? SLOT_BLANK : SLOT_DRIVE;
  end

  // Shadow capture and tear-free transfer to the display word at frame boundaries
  always_comb begin
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    if (bus.digiti_load) begin
      shadow_d  = bus.digiti_data;
      pending_d = 1'b1;
    end
    // A load landing on the boundary itself bypasses the shadow
    if (boundary) begin
      if (bus.digiti_load) begin
        display_d = bus.digiti_data;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end else if (pending_q) begin
        display_d = shadow_q;
        pending_d = 1'b0;
        ack_d     = 1'b1;
      end
    end
  end

  // Blink frame counter, free-running whether or not blink is enabled
  always_comb begin
    frame_d    = frame_q;
    blink_ph_d = blink_ph_q;
    if (boundary) begin
      if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_d    = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Leading-zero mask: digit k is a leading zero when nibbles k..top are all zero
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      all_zero = all_zero && (display_q[(NUM_DIGITS-1-i)*4 +: 4] == 4'h0);
      lz_mask[NUM_DIGITS-1-i] = all_zero;
    end
    lz_mask[0] = 1'b0;
  end

  // Current slot nibble; display cannot change during DRIVE, so the
  // registered index and word already describe the next drive cycle
  always_comb begin
    cur_nib = display_q[{idx_q, 2'b00} +: 4];
  end

  hex7_dec u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // Next output pin values, polarity applied last
  always_comb begin
    digit_off = bus.digiti_blank[idx_q]
              || (bus.digiti_lzs && lz_mask[idx_q])
              || (bus.digiti_blink && blink_ph_q);
    seg_raw   = SEG_OFF;
    sel_raw   = '0;
    if (slot_phase == SLOT_DRIVE) begin
      sel_raw = NUM_DIGITS'(1) << idx_q;
      if (!digit_off) begin
        seg_raw = cur_seg;
      end
    end
    seg_d = SEG_ACT_LOW ? ~seg_raw : seg_raw;
    sel_d = SEL_ACT_LOW ? ~sel_raw : sel_raw;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      display_q  <= '0;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
      frame_q    <= '0;
      blink_ph_q <= 1'b0;
      seg_q      <= SEG_IDLE;
      sel_q      <= SEL_IDLE;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      display_q  <= display_d;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      frame_q    <= frame_d;
      blink_ph_q <= blink_ph_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign bus.digito_seg = seg_q;
  assign bus.digito_sel = sel_q;
  assign bus.digito_ack = ack_q;

endmodule

// File: tb/tb_digit_scan.sv
// Directed bench for digit_scan with a load scoreboard: each load pushes the
// word expected to appear, each frame start pops it when an ack is due.
module tb_digit_scan;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc;
  int          checks = 0;
  int          fails  = 0;
  logic [15:0] sb_q[$];
  logic [15:0] cur;

  digit_scan_if #(.NUM_DIGITS(4)) bus ();

  digit_scan #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLANK_CYC    (1),
    .BLINK_FRAMES (2),
    .SEG_ACT_LOW  (1'b0),
    .SEL_ACT_LOW  (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; 16 cycles per frame
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected glyph for digit s during frame f of the word currently shown
  function automatic logic [6:0] exp_digit(input int s, input int f);
    logic hide;
    hide = bus.digiti_blank[s];
    if (bus.digiti_lzs && s > 0 && (cur >> (s * 4)) == 16'h0) hide = 1'b1;
    if (bus.digiti_blink && ((f / 2) % 2) == 1) hide = 1'b1;
    return hide ? 7'h00 : ref_seg(cur[s*4 +: 4]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe a load; an unacknowledged earlier load is superseded
  task automatic do_load(input logic [15:0] d);
    bus.digiti_data = d;
    bus.digiti_load = 1'b1;
    if (sb_q.size() != 0) sb_q.delete();
    sb_q.push_back(d);
  endtask

  // Check one whole frame starting at its first (blank) cycle, optionally loading
  task automatic run_frame(input string tag, input int ph1, input logic [15:0] d1,
                           input int ph2, input logic [15:0] d2);
    int         f;
    logic       exp_ack;
    logic [3:0] exp_sel;
    logic [6:0] exp_seg;
    f = int'(cyc / 16);
    for (int i = 0; i < 16; i++) begin
      exp_ack = 1'b0;
      if (i == 0 && sb_q.size() != 0) begin
        exp_ack = 1'b1;
        cur     = sb_q.pop_front();
      end
      if (i % 4 == 0) begin
        exp_sel = 4'b0000;
        exp_seg = 7'h00;
      end else begin
        exp_sel = 4'b0001 << (i / 4);
        exp_seg = exp_digit(i / 4, f);
      end
      chk($sformatf("%s/ack@%0d", tag, i), 32'(bus.digito_ack), 32'(exp_ack));
      chk($sformatf("%s/sel@%0d", tag, i), 32'(bus.digito_sel), 32'(exp_sel));
      chk($sformatf("%s/seg@%0d", tag, i), 32'(bus.digito_seg), 32'(exp_seg));
      bus.digiti_load = 1'b0;
      if (i == ph1) do_load(d1);
      if (i == ph2) do_load(d2);
      @(negedge clk);
    end
    bus.digiti_load = 1'b0;
  endtask

  initial begin
    rst              = 1'b0;
    cur              = '0;
    bus.digiti_data  = '0;
    bus.digiti_load  = 1'b0;
    bus.digiti_blank = '0;
    bus.digiti_lzs   = 1'b0;
    bus.digiti_blink = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst/seg", 32'(bus.digito_seg), 32'h00);
    chk("rst/sel", 32'(bus.digito_sel), 32'h0);
    chk("rst/ack", 32'(bus.digito_ack), 32'h0);
    rst = 1'b1;

    run_frame("idle",   -1, 16'h0000, -1, 16'h0000);
    run_frame("ld1a2f",  5, 16'h1A2F, -1, 16'h0000);
    run_frame("show1a2f", 3, 16'h1111, 9, 16'h2222);
    bus.digiti_lzs = 1'b1;
    run_frame("show2222", 15, 16'h00C0, -1, 16'h0000);
    run_frame("lzs00c0", -1, 16'h0000, -1, 16'h0000);
    run_frame("lzs00c0b", -1, 16'h0000, -1, 16'h0000);

    bus.digiti_lzs   = 1'b0;
    bus.digiti_blank = 4'b0100;
    bus.digiti_blink = 1'b1;
    for (int k = 0; k < 4; k++) run_frame($sformatf("blink%0d", k), -1, 16'h0, -1, 16'h0);
    bus.digiti_blink = 1'b0;
    bus.digiti_blank = 4'b0000;
    run_frame("unblink", -1, 16'h0000, -1, 16'h0000);

    // Reset mid-DRIVE with a load still pending
    for (int i = 0; i < 6; i++) begin
      bus.digiti_load = 1'b0;
      if (i == 2) do_load(16'h1234);
      @(negedge clk);
    end
    bus.digiti_load = 1'b0;
    chk("predrop/sel", 32'(bus.digito_sel), 32'h2);
    chk("predrop/seg", 32'(bus.digito_seg), 32'(ref_seg(cur[7:4])));
    rst = 1'b0;
    #1;
    chk("midrst/seg", 32'(bus.digito_seg), 32'h00);
    chk("midrst/sel", 32'(bus.digito_sel), 32'h0);
    chk("midrst/ack", 32'(bus.digito_ack), 32'h0);
    sb_q.delete();
    cur = '0;
    repeat (2) @(negedge clk);
    chk("inrst/sel", 32'(bus.digito_sel), 32'h0);
    rst = 1'b1;
    run_frame("postrst0", -1, 16'h0000, -1, 16'h0000);
    run_frame("postrst1", -1, 16'h0000, -1, 16'h0000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
